// File: rtl/axi2native_pkg.sv
// Shared types for the AXI4-Lite to native register bridge.
// Contents: AXI response codes and the write/read path state encodings.
package axi2native_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axi_resp_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'b00,
      W_REQ  = 2'b01,
      W_RESP = 2'b10
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'b00,
      R_REQ  = 2'b01,
      R_RESP = 2'b10
   } rd_state_t;

endpackage

// File: rtl/axi2native_if.sv
// AXI4-Lite bus bundle between an AXI master and the axi2native responder.
// Signals: aw*/w*/b* write channels, ar*/r* read channels (no prot).
// Modports: master (drives address/data/ready-for-response), slave (the bridge).
interface axi2native_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32
) ();
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi2native_wdog.sv
// Native-response watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the count reaches LIMIT. Used only when
// AXI2NATIVE_TIMEOUT_EN is defined.
// Ports: clk_i, rst_n_i (sync active-low), clr_i, en_i, expired_c (comb).
module axi2native_wdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_c
);
   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;

   // Expiry is flagged on the cycle whose increment would make the count LIMIT.
   assign expired_c = en_i && !clr_i && (cnt_q == CNT_W'(LIMIT - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != CNT_W'(LIMIT))) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/axi2native.sv
// AXI4-Lite responder re-issuing each access on the native single-beat
// register handshake. Independent write and read paths, one outstanding each.
// Ports: clk_i, rst_n_i (sync active-low), s_axi (AXI4-Lite slave),
//        wr_* native write request/response, rd_* native read request/response.
// Optional: AXI2NATIVE_TIMEOUT_EN adds a per-path watchdog of TIMEOUT_CYCLES.
module axi2native
   import axi2native_pkg::*;
#(
   parameter int unsigned ADDR_W         = 4,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   axi2native_if.slave         s_axi,
   output logic                wr_valid_o,
   output logic [ADDR_W-1:0]   wr_addr_o,
   output logic [DATA_W-1:0]   wr_data_o,
   output logic [DATA_W/8-1:0] wr_strb_o,
   input  logic                wr_ready_i,
   input  logic                wr_err_i,
   output logic                rd_valid_o,
   output logic [ADDR_W-1:0]   rd_addr_o,
   input  logic                rd_ready_i,
   input  logic [DATA_W-1:0]   rd_data_i,
   input  logic                rd_err_i
);
   localparam int unsigned STRB_W = DATA_W / 8;

   wr_state_t         wr_state_q, wr_state_d;
   logic              aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
   logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic              wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
   logic              bvalid_q, bvalid_d;
   axi_resp_t         bresp_q, bresp_d;

   rd_state_t         rd_state_q, rd_state_d;
   logic              ar_ready_q, ar_ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   axi_resp_t         rresp_q, rresp_d;

   logic wr_expired_c, rd_expired_c;

`ifdef AXI2NATIVE_TIMEOUT_EN
   axi2native_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wr_wdog (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (wr_state_q != W_REQ),
      .en_i      (!wr_ready_i),
      .expired_c (wr_expired_c)
   );
   axi2native_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_rd_wdog (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (rd_state_q != R_REQ),
      .en_i      (!rd_ready_i),
      .expired_c (rd_expired_c)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign wr_expired_c   = 1'b0;
   assign rd_expired_c   = 1'b0;
`endif

   // Write path next state: AW and W gathered in any order, then one native beat.
   always_comb begin
      wr_state_d = wr_state_q;
      aw_ready_d = aw_ready_q;
      w_ready_d  = w_ready_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_strb_d  = wr_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      case (wr_state_q)
         W_IDLE: begin
            if (aw_ready_q && s_axi.awvalid) begin
               aw_held_d = 1'b1;
               wr_addr_d = s_axi.awaddr;
            end
            if (w_ready_q && s_axi.wvalid) begin
               w_held_d  = 1'b1;
               wr_data_d = s_axi.wdata;
               wr_strb_d = s_axi.wstrb;
            end
            if (aw_held_d && w_held_d) begin
               wr_state_d = W_REQ;
               wr_valid_d = 1'b1;
               aw_ready_d = 1'b0;
               w_ready_d  = 1'b0;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
            end else begin
               aw_ready_d = !aw_held_d;
               w_ready_d  = !w_held_d;
            end
         end
         W_REQ: begin
            if (wr_ready_i) begin
               wr_state_d = W_RESP;
               wr_valid_d = 1'b0;
               bvalid_d   = 1'b1;
               bresp_d    = wr_err_i ? SLVERR : OKAY;
            end else if (wr_expired_c) begin
               wr_state_d = W_RESP;
               wr_valid_d = 1'b0;
               bvalid_d   = 1'b1;
               bresp_d    = SLVERR;
            end
         end
         W_RESP: begin
            if (s_axi.bready) begin
               wr_state_d = W_IDLE;
               bvalid_d   = 1'b0;
               aw_ready_d = 1'b1;
               w_ready_d  = 1'b1;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // Read path next state: capture AR, one native beat, hold R until taken.
   always_comb begin
      rd_state_d = rd_state_q;
      ar_ready_d = ar_ready_q;
      rd_valid_d = rd_valid_q;
      rd_addr_d  = rd_addr_q;
      rdata_d    = rdata_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         R_IDLE: begin
            ar_ready_d = 1'b1;
            if (ar_ready_q && s_axi.arvalid) begin
               rd_state_d = R_REQ;
               ar_ready_d = 1'b0;
               rd_valid_d = 1'b1;
               rd_addr_d  = s_axi.araddr;
            end
         end
         R_REQ: begin
            if (rd_ready_i) begin
               rd_state_d = R_RESP;
               rd_valid_d = 1'b0;
               rvalid_d   = 1'b1;
               rdata_d    = rd_data_i;
               rresp_d    = rd_err_i ? SLVERR : OKAY;
            end else if (rd_expired_c) begin
               rd_state_d = R_RESP;
               rd_valid_d = 1'b0;
               rvalid_d   = 1'b1;
               rdata_d    = '0;
               rresp_d    = SLVERR;
            end
         end
         R_RESP: begin
            if (s_axi.rready) begin
               rd_state_d = R_IDLE;
               rvalid_d   = 1'b0;
               ar_ready_d = 1'b1;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // State and output registers for both paths.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_state_q <= W_IDLE;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_strb_q  <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= OKAY;
         rd_state_q <= R_IDLE;
         ar_ready_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         rresp_q    <= OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_strb_q  <= wr_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         ar_ready_q <= ar_ready_d;
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
      end
   end

   assign s_axi.awready = aw_ready_q;
   assign s_axi.wready  = w_ready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = ar_ready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign wr_valid_o    = wr_valid_q;
   assign wr_addr_o     = wr_addr_q;
   assign wr_data_o     = wr_data_q;
   assign wr_strb_o     = wr_strb_q;
   assign rd_valid_o    = rd_valid_q;
   assign rd_addr_o     = rd_addr_q;
endmodule
